// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job scheduler: error codes, scheduler
// state encoding and the default operand width.
package gcd_pkg;

  localparam int GCD_W = 8;

  localparam logic [1:0] GCD_OK          = 2'b00;
  localparam logic [1:0] GCD_ERR_ZERO    = 2'b01;
  localparam logic [1:0] GCD_ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_RUN    = 2'b10,
    ST_RESP   = 2'b11
  } sched_state_e;

endpackage

// File: rtl/gcd_job_scheduler_if.sv
// Bundle of requester-fabric and GCD-core handshake signals around the
// scheduler; slave is the scheduler's view, master the surrounding fabric.
interface gcd_job_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic [1:0]        rsp_err;
  logic              rsp_ready;
  logic              core_go;
  logic [W-1:0]      core_a;
  logic [W-1:0]      core_b;
  logic              core_done;
  logic [W-1:0]      core_out;
  logic              core_abort;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, core_done, core_out,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           core_go, core_a, core_b, core_abort
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, core_done, core_out,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           core_go, core_a, core_b, core_abort
  );

endinterface

// File: rtl/gcd_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around, as a one-hot vector plus encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  int   cand_s;
  logic found_s;
  logic hit_s;

  // Rotating priority scan starting at the pointer
  always_comb begin
    grant   = {NREQ{1'b0}};
    idx     = {IDW{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s        = (int'(ptr) + k) % NREQ;
      hit_s         = !found_s && req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      idx           = hit_s ? IDW'(cand_s) : idx;
      found_s       = found_s | hit_s;
    end
  end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Shares one subtractive GCD core between NREQ requesters: round-robin grant,
// zero-operand screening, run timeout with core abort, tagged result return.
module gcd_job_scheduler
  import gcd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  gcd_job_scheduler_if.slave  bus,
  output logic                busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  sched_state_e   state_r, state_n;
  logic [IDW-1:0] ptr_r, id_r;
  logic [W-1:0]   a_r, b_r, data_r;
  logic [1:0]     err_r;
  logic           rsp_valid_r, core_go_r, busy_r;
  logic [CW-1:0]  cnt_r;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [W-1:0]    a_sel_s, b_sel_s;
  logic accept_s, zero_s, done_s, timeout_s, handshake_s, abort_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (grant_idx_s)
  );

  // One-hot operand mux for the granted requester
  always_comb begin
    a_sel_s = {W{1'b0}};
    b_sel_s = {W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      a_sel_s = a_sel_s | (bus.req_a[i*W +: W] & {W{grant_s[i]}});
      b_sel_s = b_sel_s | (bus.req_b[i*W +: W] & {W{grant_s[i]}});
    end
  end

  // Next-state and per-cycle event decode
  always_comb begin
    state_n     = state_r;
    accept_s    = 1'b0;
    zero_s      = 1'b0;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    handshake_s = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          accept_s = 1'b1;
          if ((a_sel_s == {W{1'b0}}) || (b_sel_s == {W{1'b0}})) begin
            zero_s  = 1'b1;
            state_n = ST_RESP;
          end else begin
            state_n = ST_LAUNCH;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LAUNCH: state_n = ST_RUN;
      ST_RUN: begin
        // Completion takes priority over a coincident timeout
        if (bus.core_done) begin
          done_s  = 1'b1;
          state_n = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s = 1'b1;
          abort_s   = 1'b1;
          state_n   = ST_RESP;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          handshake_s = 1'b1;
          state_n     = ST_IDLE;
        end else begin
          state_n = ST_RESP;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, pointer, run counter and launch pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {IDW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      core_go_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      core_go_r <= (state_n == ST_LAUNCH);
      busy_r    <= (state_n != ST_IDLE);
      if (state_r == ST_LAUNCH) begin
        cnt_r <= {CW{1'b0}};
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (handshake_s) begin
        ptr_r <= (id_r == ID_LAST) ? {IDW{1'b0}} : id_r + IDW'(1);
      end
    end
  end

  // Captured job and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_r        <= {IDW{1'b0}};
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      data_r      <= {W{1'b0}};
      err_r       <= GCD_OK;
      rsp_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        id_r <= grant_idx_s;
        a_r  <= a_sel_s;
        b_r  <= b_sel_s;
      end
      if (accept_s && zero_s) begin
        data_r      <= {W{1'b0}};
        err_r       <= GCD_ERR_ZERO;
        rsp_valid_r <= 1'b1;
      end else if (done_s) begin
        data_r      <= bus.core_out;
        err_r       <= GCD_OK;
        rsp_valid_r <= 1'b1;
      end else if (timeout_s) begin
        data_r      <= {W{1'b0}};
        err_r       <= GCD_ERR_TIMEOUT;
        rsp_valid_r <= 1'b1;
      end else if (handshake_s) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  // Grant is only offered while idle; abort must see this cycle's core_done
  assign bus.req_ready  = grant_s & {NREQ{state_r == ST_IDLE}};
  assign bus.core_abort = abort_s;
  assign bus.core_go    = core_go_r;
  assign bus.core_a     = a_r;
  assign bus.core_b     = b_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = id_r;
  assign bus.rsp_data   = data_r;
  assign bus.rsp_err    = err_r;
  assign busy           = busy_r;

endmodule

// File: doc/gcd_job_scheduler.md
# gcd_job_scheduler

Round-robin scheduler that shares one GCD core (go/done handshake, two W-bit operands, W-bit result) between NREQ requesters. Each request carries an operand pair; the scheduler grants one requester at a time and launches the core. It screens zero operands, which the subtractive core cannot terminate on. It enforces a cycle timeout and returns a tagged result with an error code. It sits between the requester fabric and the GCD controller/datapath pair in the top level.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width
- TIMEOUT, 1023, max RUN cycles before abort (>=2)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_a  in  NREQ*W  packed operand A, requester i at [i*W +: W]
- req_b  in  NREQ*W  packed operand B
- req_ready  out  NREQ  one-hot accept, combinational
- rsp_valid  out  1  result available
- rsp_id  out  clog2(NREQ)  requester index of result
- rsp_data  out  W  GCD result (0 on error)
- rsp_err  out  2  00 ok, 01 zero operand, 10 timeout
- rsp_ready  in  1  consumer accepts result
- core_go  out  1  one-cycle start pulse to core
- core_a  out  W  operand A to core, held stable IDLE->RESP
- core_b  out  W  operand B to core
- core_done  in  1  core completion
- core_out  in  W  core result, valid with core_done
- core_abort  out  1  one-cycle pulse, clears core on timeout
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LAUNCH, RUN, RESP.
- Reset values: state IDLE, rr pointer 0, all outputs 0, cycle counter 0.
- IDLE: if any req_valid, rr_arbiter picks the first valid index at or after the pointer (wrapping). It drives req_ready for that index only. It captures the operands and id on the edge.
  - Either captured operand == 0: go to RESP with err 01 and data 0. The core is not started.
  - Otherwise go to LAUNCH.
- LAUNCH: core_go=1 for exactly one cycle; counter cleared; go to RUN.
- RUN: counter increments each cycle.
  - core_done=1: capture core_out, err 00, go to RESP.
  - Else, if counter == TIMEOUT-1: core_abort=1 for one cycle, data 0, err 10, go to RESP.
  - If core_done and timeout occur in the same cycle, done wins.
- RESP: rsp_valid held with stable id/data/err until rsp_ready. On the handshake: pointer = granted id + 1 (mod NREQ), go to IDLE.
- core_done outside RUN is ignored.
- A requester dropping req_valid before it is granted has no effect.
- Equal non-zero operands are dispatched normally.
- req_ready is 0 in every state except IDLE.
- Reset at any point returns to IDLE and drops rsp_valid/core_go immediately. The in-flight job is lost and not reported.

## Timing
- Accept edge = cycle 0.
- core_go high in cycle 1; RUN from cycle 2.
- core_done sampled high in cycle k: rsp_valid high from cycle k+1.
- Zero-operand reject: rsp_valid high in cycle 1.
- Timeout: core_abort in RUN cycle TIMEOUT-1 (cycle TIMEOUT+1 after accept); rsp_valid the next cycle.
- rsp_valid and rsp_ready in the same cycle: IDLE next cycle. The earliest next grant is that IDLE cycle, so there is at least one bubble between jobs.

## Structure
- Shared package gcd_pkg:
  - err code constants GCD_OK / GCD_ERR_ZERO / GCD_ERR_TIMEOUT
  - scheduler state enum
  - default W
- Sub-module rr_arbiter:
  - inputs: NREQ request vector, pointer
  - output: one-hot grant plus encoded index
  - purely combinational

## Test plan
- Single job, stub core with 5-cycle latency. Requester 2 sends 48,18 -> core_go in cycle 1; rsp_valid, rsp_id=2, rsp_data=6, err 00 in cycle 7.
- All four requesters valid continuously, pointer 0 -> grants in order 0,1,2,3,0. No requester is granted twice before each other valid requester is granted once.
- Requester 1 sends 0,25 -> core_go never asserts; rsp_valid in cycle 1 with data 0, err 01.
- Stub core never asserts done, TIMEOUT=16 -> one core_abort pulse in RUN cycle 15; rsp err 10, data 0. The next job proceeds normally.
- rsp_ready held low 10 cycles with other req_valid high -> rsp fields stable, req_ready stays 0. Then one ready cycle -> IDLE and the next grant follows.
- rst low mid-RUN -> outputs 0 asynchronously. After release, the pointer is 0 and a fresh 12,8 job returns 4.
